data_mem_ws: RTL



---
 rtl/data_mem_ws.sv | 123 ++++++++++++
 1 files changed

// File: rtl/data_mem_ws.sv
// Single-port data memory with a req/ack handshake and configurable wait states.
// A clear sweep after reset zeroes every word before the first access is accepted.
module data_mem_ws #(
    parameter int WIDTH       = 21,
    parameter int ADDR_BITS   = 6,
    parameter int WAIT_STATES = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [WIDTH-1:0]     wdata,
    output logic [WIDTH-1:0]     rdata,
    output logic                 ack,
    output logic                 busy
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_WAIT
    } state_t;

    state_t               state_q, state_d;
    logic [ADDR_BITS-1:0] ptr_q, ptr_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 we_q, we_d;
    logic [WIDTH-1:0]     wdata_q, wdata_d;
    logic [WIDTH-1:0]     rdata_q, rdata_d;
    logic                 ack_q, ack_d;

    logic [WIDTH-1:0]     mem [DEPTH];
    logic                 mem_we;
    logic [ADDR_BITS-1:0] mem_waddr;
    logic [WIDTH-1:0]     mem_wdata;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        ack_d     = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = ptr_q;
        mem_wdata = '0;
        case (state_q)
            ST_INIT: begin
                mem_we = 1'b1;
                ptr_d  = ptr_q + 1'b1;
                if (&ptr_q) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (req) begin
                    we_d    = we;
                    addr_d  = addr;
                    wdata_d = wdata;
                    cnt_d   = 4'(WAIT_STATES);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    // Access edge: only the latched request is used from here on.
                    ack_d   = 1'b1;
                    state_d = ST_IDLE;
                    if (we_q) begin
                        mem_we    = 1'b1;
                        mem_waddr = addr_q;
                        mem_wdata = wdata_q;
                    end else begin
                        rdata_d = mem[addr_q];
                    end
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_INIT;
            ptr_q   <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
        end
    end

    // Gating with rst guarantees an aborted access never reaches the array.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign rdata = rdata_q;
    assign ack   = ack_q;
    assign busy  = (state_q != ST_IDLE);

endmodule
